// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and defaults for the operand-fetch stage that feeds the 16-bit
// shifter/ALU pair.
//   state_t     : operand_fetch sequencing states
//   shift_op_t  : 2-bit shift code carried unmodified to the shifter
//   DEF_WIDTH   : default data width
//   DEF_NREGS   : default register-file depth
//   fetch_ready : command-acceptance condition, shared by the FSM and port
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } state_t;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SH_PASS = 2'b00;
  localparam shift_op_t SH_LSL  = 2'b01;
  localparam shift_op_t SH_LSR  = 2'b10;
  localparam shift_op_t SH_ASR  = 2'b11;

  // A new command may enter when the stage is empty, or when the presented
  // operands are being consumed in this very cycle (back-to-back issue).
  function automatic logic fetch_ready(state_t s, logic consume);
    return (s == IDLE) || ((s == VALID) && consume);
  endfunction

endpackage : fetch_pkg

// File: rtl/operand_regfile.sv
// -----------------------------------------------------------------------------
// operand_regfile
// NREGS x WIDTH general register file with one synchronous write port and one
// combinational read port. A read of the index being written in the same cycle
// returns the write data (write-through bypass).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every register)
//   wr_en      : write enable
//   wr_num     : write index
//   wr_data    : write data
//   rd_num     : read index
//   rd_data    : read data (bypassed from wr_data on an index match)
// -----------------------------------------------------------------------------
module operand_regfile
  import fetch_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_num,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_num,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [NREGS];

  // NOTE: this storage is reset on purpose -- a read after reset must return
  // zero, so it builds as flops with clear rather than as a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_num] <= wr_data;
    end
  end

  // NOTE: rd_data is assigned on every path through this block, so no latch
  // can be inferred.
  always_comb begin
    if (wr_en && (wr_num == rd_num)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem[rd_num];
    end
  end

endmodule : operand_regfile

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Operand-staging stage upstream of the 16-bit shifter/ALU pair. A command
// names two registers; they are read through a single read port over two
// cycles (A, then B) into holding registers and presented with the shift
// code until the downstream consumer accepts them.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : command request, taken only while ready=1
//   rnum_a, rnum_b    : register indices for operands A and B
//   shift_in          : shift code (00 pass, 01 lsl1, 10 lsr1, 11 asr1)
//   asel              : 1 forces operand A to zero
//   wr_en/wr_num/     : register-file write port, usable in any state
//   wr_data
//   consume           : downstream accepts the presented operands
//   ready             : a command can be taken this cycle
//   valid             : ain/sin/shift are stable and usable
//   ain               : latched operand A (to the ALU)
//   sin               : latched operand B (to the shifter data input)
//   shift             : latched shift code (to the shifter select)
// -----------------------------------------------------------------------------
module operand_fetch
  import fetch_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    rnum_a,
  input  logic [AW-1:0]    rnum_b,
  input  logic [1:0]       shift_in,
  input  logic             asel,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_num,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             consume,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] sin,
  output logic [1:0]       shift
);

  state_t           state;

  // Captured command fields. The read index always comes from these, never
  // from the live rnum_* inputs, which may change after acceptance.
  logic [AW-1:0]    cmd_a;
  logic [AW-1:0]    cmd_b;
  shift_op_t        cmd_shift;
  logic             cmd_asel;

  // Holding registers presented downstream.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  shift_op_t        shift_q;
  logic             valid_q;

  logic [AW-1:0]    rd_num;
  logic [WIDTH-1:0] rd_data;
  logic             take;

  assign ready = fetch_ready(state, consume);
  assign take  = start && ready;

  // The single read port serves A in READ_A and B in READ_B; in other states
  // its output is ignored.
  assign rd_num = (state == READ_B) ? cmd_b : cmd_a;

  operand_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_num  (rd_num),
    .rd_data (rd_data)
  );

  // NOTE: every state register here uses non-blocking assignment so all of
  // them update together from pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_a     <= '0;
      cmd_b     <= '0;
      cmd_shift <= SH_PASS;
      cmd_asel  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      shift_q   <= SH_PASS;
      valid_q   <= 1'b0;
    end else begin
      // Command capture is shared by IDLE and the back-to-back path in VALID.
      if (take) begin
        cmd_a     <= rnum_a;
        cmd_b     <= rnum_b;
        cmd_shift <= shift_op_t'(shift_in);
        cmd_asel  <= asel;
      end

      unique case (state)
        IDLE: begin
          if (take) begin
            state <= READ_A;
          end
        end

        READ_A: begin
          a_q   <= cmd_asel ? '0 : rd_data;
          state <= READ_B;
        end

        READ_B: begin
          // Shift code is latched with B so sin and shift always change
          // together as one presented pair.
          b_q     <= rd_data;
          shift_q <= cmd_shift;
          valid_q <= 1'b1;
          state   <= VALID;
        end

        VALID: begin
          // Without consume everything holds; register writes in this state
          // reach only the register file, never a_q/b_q.
          if (consume) begin
            valid_q <= 1'b0;
            state   <= take ? READ_A : IDLE;
          end
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign ain   = a_q;
  assign sin   = b_q;
  assign shift = shift_q;

endmodule : operand_fetch

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Sequential operand-staging stage that sits directly upstream of the 16-bit shifter/ALU pair.
- Holds the 8x16 general register file and fetches two operands through a single read port over two cycles.
- Latches the operands into A and B holding registers, then presents A to the ALU and B, with its shift code, to the shifter.
- Uses a valid/consume handshake so operands stay stable until downstream accepts them.

Parameters:
- WIDTH, 16, data width of registers and operands
- NREGS, 8, number of registers (address width AW = $clog2(NREGS) = 3)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command request; accepted only when ready=1
- rnum_a  in  AW  register index for operand A
- rnum_b  in  AW  register index for operand B
- shift_in  in  2  shift code (00 pass, 01 lsl1, 10 lsr1, 11 asr1)
- asel  in  1  1 = force A to zero instead of reading the register file
- wr_en  in  1  register-file write enable
- wr_num  in  AW  write index
- wr_data  in  WIDTH  write data
- consume  in  1  downstream accepts the presented operands
- ready  out  1  high in IDLE, or in VALID while consume=1
- valid  out  1  operands on ain/sin/shift are stable and usable
- ain  out  WIDTH  latched A operand
- sin  out  WIDTH  latched B operand, wired to the shifter input
- shift  out  2  latched shift code, wired to the shifter shift select

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All registers, A, B and the latched shift code clear to 0.
  - Outputs: valid=0, ready=1, ain=0, sin=0, shift=2'b00.
  - Reset asserted mid-command aborts the command; no partial result is ever flagged valid.
- FSM states are IDLE, READ_A, READ_B, VALID.
  - IDLE: ready=1. On start, capture rnum_a, rnum_b, shift_in and asel, then go to READ_A. Without start, stay in IDLE.
  - READ_A: A <= asel ? 0 : rf[rnum_a]. Go to READ_B.
  - READ_B: B <= rf[rnum_b]. Go to VALID.
  - VALID: valid=1, and ain/sin/shift hold their values.
    - On consume with no start, go to IDLE.
    - On consume and start in the same cycle, capture the new command and go to READ_A (back-to-back operation).
    - Without consume, stay in VALID indefinitely.
- Latency:
  - start is accepted at edge N.
  - valid rises after edge N+2 and stays high until consume is sampled.
  - Throughput is one command per 3 cycles when consume is tied high.
- start is ignored whenever ready=0. It is not queued.
- Register file:
  - Writes are synchronous on wr_en and may occur in any state.
  - A read in READ_A or READ_B of the index being written in the same cycle returns wr_data (write-through bypass).
  - A write during VALID does not alter the latched A/B values.
  - The read index always comes from the captured command fields, never from live inputs.
- Widths:
  - No arithmetic is performed.
  - Indices are exactly AW bits, so there is no out-of-range access when NREGS = 2^AW.
- The shift code is passed unmodified. Shifting itself is done downstream.

Decomposition:
- Shared package fetch_pkg:
  - typedef enum state_t {IDLE, READ_A, READ_B, VALID}.
  - typedef logic [1:0] shift_op_t, with constants SH_PASS=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11.
  - Localparam defaults for WIDTH and NREGS.
- One sub-module, operand_regfile: NREGS x WIDTH storage, async-reset clear, one synchronous write port, one combinational read port with write-through bypass.
- The FSM, command capture and A/B latches remain in operand_fetch.

Test Plan:
- Reset, then write R3=16'hF0CF and R5=16'h0001. Issue start with rnum_a=5, rnum_b=3, shift_in=2'b11, asel=0 -> valid rises 3 edges later with ain=16'h0001, sin=16'hF0CF, shift=2'b11. The downstream shifter then yields 16'hF867.
- Hold consume=0 for 10 cycles while writing R3=16'h1234 -> valid stays 1, sin stays 16'hF0CF. Pulse consume -> valid=0, ready=1 the next cycle.
- Same-cycle hazard: in READ_B, wr_en=1, wr_num=3, wr_data=16'hAAAA with rnum_b=3 -> sin=16'hAAAA.
- asel=1 with rnum_a=3 (R3=16'hF0CF) -> ain=16'h0000. Issue start while valid=1 and consume=0 -> command ignored, outputs unchanged.
- Back-to-back: consume=1 and start=1 in VALID with a new command (rnum_b=5, shift_in=2'b01) -> valid drops for 2 cycles, then re-asserts with sin=16'h0001, shift=2'b01.
- Assert rst_n=0 during READ_B -> valid=0, ain=sin=0, shift=0 immediately. After release, reading any register returns 0.
